// File: rtl/fifo_mem_param.sv
// Synchronous FIFO with parameterised width/depth, programmable fill threshold,
// sticky over/underflow flags and optional first-word-fall-through read port.
module fifo_mem_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH:0]   thresh,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  fifo_threshold,
   output logic                  fifo_overflow,
   output logic                  fifo_underflow,
   output logic                  ovf_sticky,
   output logic                  udf_sticky,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  ovf_q, udf_q;
   logic                  ovf_sticky_q, udf_sticky_q;
   logic                  wr_ok, rd_ok;

   // A write into a full FIFO is still accepted when a read frees a slot this cycle.
   always_comb begin
      rd_ok    = rd && (count_q != '0);
      wr_ok    = wr && ((count_q != DEPTH_CNT) || rd_ok);
      wr_ptr_d = wr_ok ? wr_ptr_q + ONE : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + ONE : rd_ptr_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !rst) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
         udf_sticky_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= wr && !wr_ok;
         udf_q    <= rd && !rd_ok;
         if (wr && !wr_ok) begin
            ovf_sticky_q <= 1'b1;
         end else if (err_clr) begin
            ovf_sticky_q <= 1'b0;
         end
         if (rd && !rd_ok) begin
            udf_sticky_q <= 1'b1;
         end else if (err_clr) begin
            udf_sticky_q <= 1'b0;
         end
      end
   end

   generate
      if (FWFT == 0) begin : g_std
         always_ff @(posedge clk) begin
            if (rst) begin
               data_out_q <= '0;
            end else if (rd_ok) begin
               data_out_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
         end
      end else begin : g_fwft
         // The next head can only coincide with the write slot when the FIFO is
         // (about to be) empty, so the incoming word is forwarded straight out.
         logic head_bypass;
         assign head_bypass = wr_ok && (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);

         always_ff @(posedge clk) begin
            if (rst) begin
               data_out_q <= '0;
            end else if (head_bypass) begin
               data_out_q <= data_in;
            end else begin
               data_out_q <= mem[rd_ptr_d[ADDR_WIDTH-1:0]];
            end
         end
      end
   endgenerate

   assign data_out       = data_out_q;
   assign count          = count_q;
   assign fifo_full      = (count_q == DEPTH_CNT);
   assign fifo_empty     = (count_q == '0);
   assign fifo_threshold = (count_q >= thresh);
   assign fifo_overflow  = ovf_q;
   assign fifo_underflow = udf_q;
   assign ovf_sticky     = ovf_sticky_q;
   assign udf_sticky     = udf_sticky_q;

endmodule

// File: tb/tb_fifo_mem_param.sv
// Directed checks of fifo_mem_param: a default (registered-read) instance and an FWFT instance.
module tb_fifo_mem_param;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, wr, rd, err_clr;
   logic [7:0] din, dout;
   logic [4:0] thresh, cnt;
   logic       full, empty, thr, ovf, udf, ovfs, udfs;

   logic       f_rst, f_wr, f_rd, f_err_clr;
   logic [7:0] f_din, f_dout;
   logic [4:0] f_thresh, f_cnt;
   logic       f_full, f_empty, f_thr, f_ovf, f_udf, f_ovfs, f_udfs;

   int errors = 0;
   int checks = 0;

   fifo_mem_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut (
      .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(din), .thresh(thresh),
      .err_clr(err_clr), .data_out(dout), .fifo_full(full), .fifo_empty(empty),
      .fifo_threshold(thr), .fifo_overflow(ovf), .fifo_underflow(udf),
      .ovf_sticky(ovfs), .udf_sticky(udfs), .count(cnt)
   );

   fifo_mem_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
      .clk(clk), .rst(f_rst), .wr(f_wr), .rd(f_rd), .data_in(f_din), .thresh(f_thresh),
      .err_clr(f_err_clr), .data_out(f_dout), .fifo_full(f_full), .fifo_empty(f_empty),
      .fifo_threshold(f_thr), .fifo_overflow(f_ovf), .fifo_underflow(f_udf),
      .ovf_sticky(f_ovfs), .udf_sticky(f_udfs), .count(f_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0; thresh = 5'd8; err_clr = 1'b0;
      f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_din = '0; f_thresh = 5'd1; f_err_clr = 1'b0;
      step;
      rst = 1'b0; f_rst = 1'b0;

      check("rst_count", cnt, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_dout", dout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_udf", udf, 0);
      check("rst_stk", {ovfs, udfs}, 0);
      check("f_rst_dout", f_dout, 0);

      // Fill 0x01..0x10; threshold (8) rises on the edge count reaches 8
      for (int i = 1; i <= 16; i++) begin
         wr = 1'b1; din = 8'(i);
         step;
         check("thr_fill", thr, i >= 8);
      end
      wr = 1'b0;
      check("full_flag", full, 1);
      check("full_count", cnt, 16);

      wr = 1'b1; din = 8'h11;
      step;
      wr = 1'b0;
      check("ovf_pulse", ovf, 1);
      check("ovf_sticky", ovfs, 1);
      check("ovf_count", cnt, 16);
      step;
      check("ovf_single", ovf, 0);
      check("ovf_hold", ovfs, 1);

      // Drain: data in order, threshold falls when count returns to 7
      for (int i = 1; i <= 16; i++) begin
         rd = 1'b1;
         step;
         check("drain_data", dout, 8'(i));
         check("thr_drain", thr, (16 - i) >= 8);
      end
      step;
      rd = 1'b0;
      check("udf_pulse", udf, 1);
      check("udf_sticky", udfs, 1);
      check("udf_dout", dout, 8'h10);
      check("udf_empty", empty, 1);
      step;
      check("udf_single", udf, 0);

      // Sticky set wins over a coincident clear; plain clear drops the other
      rd = 1'b1; err_clr = 1'b1;
      step;
      rd = 1'b0;
      check("clr_set_wins", udfs, 1);
      check("clr_ovf", ovfs, 0);
      step;
      err_clr = 1'b0;
      check("clr_udf", udfs, 0);

      thresh = 5'd0;
      step;
      check("thr_zero", thr, 1);
      thresh = 5'd17;
      step;
      check("thr_above_empty", thr, 0);

      // wr+rd while empty: write taken, read rejected
      wr = 1'b1; rd = 1'b1; din = 8'h55;
      step;
      wr = 1'b0; rd = 1'b0;
      check("wrrd_empty_cnt", cnt, 1);
      check("wrrd_empty_udf", udf, 1);
      check("wrrd_empty_dout", dout, 8'h10);
      rd = 1'b1;
      step;
      rd = 1'b0;
      check("wrrd_empty_data", dout, 8'h55);
      check("wrrd_empty_e", empty, 1);

      // Refill, then simultaneous wr+rd at full across the wrap
      for (int i = 1; i <= 16; i++) begin
         wr = 1'b1; din = 8'(i);
         step;
      end
      wr = 1'b0;
      check("thr_above_full", thr, 0);
      thresh = 5'd16;
      step;
      check("thr_eq_depth", thr, 1);
      for (int k = 0; k < 4; k++) begin
         wr = 1'b1; rd = 1'b1; din = 8'(8'h20 + k);
         step;
         check("full_wrrd_dout", dout, 8'(k + 1));
         check("full_wrrd_cnt", cnt, 16);
         check("full_wrrd_ovf", ovf, 0);
      end
      wr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd = 1'b1;
         step;
         check("wrap_data", dout, (i < 12) ? 8'(5 + i) : 8'(8'h20 + i - 12));
      end
      rd = 1'b0;
      check("wrap_empty", empty, 1);

      // Reset mid-operation with count=5 and ovf_sticky set
      for (int i = 0; i < 17; i++) begin
         wr = 1'b1; din = 8'(8'h40 + i);
         step;
      end
      wr = 1'b0;
      for (int i = 0; i < 11; i++) begin
         rd = 1'b1;
         step;
      end
      rd = 1'b0;
      check("pre_rst_cnt", cnt, 5);
      check("pre_rst_ovfs", ovfs, 1);
      rst = 1'b1; wr = 1'b1; din = 8'h99;
      step;
      rst = 1'b0; wr = 1'b0;
      check("mid_rst_cnt", cnt, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_ovfs", ovfs, 0);
      check("mid_rst_dout", dout, 0);
      wr = 1'b1; din = 8'h77;
      step;
      wr = 1'b0; rd = 1'b1;
      step;
      rd = 1'b0;
      check("post_rst_data", dout, 8'h77);
      check("post_rst_empty", empty, 1);

      // FWFT instance
      f_wr = 1'b1; f_din = 8'hA5;
      step;
      f_wr = 1'b0;
      check("fwft_empty", f_empty, 0);
      check("fwft_first", f_dout, 8'hA5);
      f_wr = 1'b1; f_din = 8'h5A;
      step;
      f_wr = 1'b0;
      check("fwft_hold", f_dout, 8'hA5);
      check("fwft_cnt2", f_cnt, 2);
      f_rd = 1'b1;
      step;
      f_rd = 1'b0;
      check("fwft_pop", f_dout, 8'h5A);
      check("fwft_cnt1", f_cnt, 1);
      f_wr = 1'b1; f_rd = 1'b1; f_din = 8'h3C;
      step;
      f_wr = 1'b0; f_rd = 1'b0;
      check("fwft_bypass", f_dout, 8'h3C);
      check("fwft_bypass_cnt", f_cnt, 1);
      f_rd = 1'b1;
      step;
      f_rd = 1'b0;
      check("fwft_drained", f_empty, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_mem_param.md
FIFO_MEM_PARAM -- requirements
Module: fifo_mem_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8: bit width of each stored word.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 4: log2 of depth; DEPTH = 2**ADDR_WIDTH (16 by default).
REQ-003 SHALL provide parameter FWFT, default 0: 0 = standard registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 wr  input  1  write request.
REQ-008 rd  input  1  read/pop request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 thresh  input  ADDR_WIDTH+1  programmable fill threshold.
REQ-011 err_clr  input  1  clears sticky error bits.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 fifo_full, fifo_empty, fifo_threshold  output  1 each  status flags.
REQ-014 fifo_overflow, fifo_underflow  output  1 each  single-cycle error pulses.
REQ-015 ovf_sticky, udf_sticky  output  1 each  latched error bits.
REQ-016 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-017 SHALL use write/read pointers of ADDR_WIDTH+1 bits: low bits address memory, MSB tracks wrap, and wrap DEPTH-1 -> 0 without a gap.
REQ-018 SHALL accept a write when wr=1 and either count<DEPTH, or count==DEPTH and a read is accepted in the same cycle.
REQ-019 SHALL accept a read when rd=1 and count>0; at count==0 a simultaneous wr is accepted, but the read is rejected.
REQ-020 SHALL update count per edge: +1 for write only, -1 for read only, unchanged for both or neither.
REQ-021 fifo_full SHALL equal (count==DEPTH), fifo_empty (count==0), and fifo_threshold (count>=thresh), all decoded from registered count, so they change on the same edge as count.
REQ-022 fifo_overflow SHALL be high for exactly the cycle after each rejected write; fifo_underflow likewise for each rejected read.
REQ-023 A rejected write SHALL modify neither memory, pointers nor count; a rejected read SHALL modify neither pointers nor data_out.
REQ-024 ovf_sticky/udf_sticky SHALL set together with the corresponding pulse and hold until err_clr=1 or rst; when a set and err_clr coincide, the set SHALL win.
REQ-025 FWFT=0: data_out SHALL load the head word on the edge accepting a read (one-cycle latency) and hold otherwise.
REQ-026 FWFT=1: data_out SHALL present the head word whenever fifo_empty=0, a word written into an empty FIFO appearing one cycle after its write edge; an accepted read pops and the next word appears the following cycle; data_out is don't-care while empty.
REQ-027 Data SHALL be returned in strict write order across any number of pointer wraps.
REQ-028 thresh values above DEPTH SHALL hold fifo_threshold low; thresh=0 SHALL hold it high.

Reset
REQ-029 With rst=1 at a rising edge, pointers, count, data_out, fifo_overflow, fifo_underflow and both sticky bits SHALL become 0, fifo_empty 1, fifo_full 0; memory contents are not reset.
REQ-030 rst SHALL take priority over wr, rd and err_clr in the same cycle, and a reset mid-operation SHALL discard all stored words.

Verification
REQ-031 Defaults, after reset: write 0x01..0x10 on 16 consecutive cycles -> fifo_full=1, count=16; 17th write of 0x11 -> fifo_overflow pulses once, ovf_sticky=1, contents unchanged.
REQ-032 From full, 17 reads -> data_out 0x01..0x10 in order, each one cycle after its read edge; 17th read -> fifo_underflow pulse, udf_sticky=1, data_out stays 0x10.
REQ-033 thresh=8, writes from empty -> fifo_threshold rises on the edge where count becomes 8 and falls on the read edge where count returns to 7.
REQ-034 At full, wr=1 and rd=1 for 4 cycles with 0x20..0x23 -> count stays 16, no overflow, and later reads return 0x05..0x10 then 0x20..0x23 (wrap verified).
REQ-035 FWFT=1: write 0xA5 into empty -> data_out=0xA5 and fifo_empty=0 one cycle later with no rd; a pop with 0x5A queued -> data_out=0x5A next cycle.
REQ-036 With count=5 and ovf_sticky=1, assert rst with wr=1 -> next cycle count=0, fifo_empty=1, ovf_sticky=0, and that write is not stored.
